// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants for the parametrised UART receive controller:
//   - 3-bit FSM state encodings (IDLE, START, DATA, PARITY, STOP, BREAK)
//   - legal oversampling ratios for the prescale input
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// ---------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversample (edge) and bit counters for the UART RX controller.
// Ports:
//   clck        system clock
//   rst         asynchronous active-low reset
//   en          count enable (high while a frame is in progress)
//   clr         synchronous clear of both counters (has priority over en)
//   prescale    oversampling ratio; edge_cnt runs 0..prescale-1
//   edge_cnt    oversample position within the current bit
//   bit_cnt     bit index within the frame (0 = start bit)
//   end_of_bit  high in the last oversample cycle of a bit while enabled
// ---------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  end_of_bit
);

  assign end_of_bit = en && (edge_cnt == (prescale - PRESCALE_W'(1)));

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (end_of_bit) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl_p.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_p
// Parametrised UART receive controller. Sequences START/DATA/PARITY/STOP,
// generates sampling and check strobes for the external sampler,
// deserializer, parity and stop checkers, and reports the frame outcome
// (data_valid, framing_err, parity_err, break_det) in the last frame cycle.
// Ports:
//   clck, rst            clock, asynchronous active-low reset
//   RX_IN                synchronised serial line, idle high
//   prescale             oversampling ratio (8, 16 or 32)
//   par_en, stop2        parity present, two stop bits
//   sampled_bit          majority-voted bit, valid while samp_done=1
//   strt_glitch          start checker result, cycle after strt_chk_en
//   par_check_err        parity checker result, cycle after par_chk_en
//   stop_err             stop checker result, cycle after stop_chk_en
//   edge_cnt, bit_cnt    oversample position / bit index in frame
//   samp_en, samp_done   sampler enable / sampling-point strobe
//   strt_chk_en, deser_en, par_chk_en, stop_chk_en   per-state strobes
//   data_valid, framing_err, parity_err, break_det   outcome pulses
// prescale, par_en and stop2 are shadowed when a frame starts, so changes
// mid-frame only take effect on the next frame.
// ---------------------------------------------------------------------------
module uart_rx_ctrl_p
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  stop2,
  input  logic                  sampled_bit,
  input  logic                  strt_glitch,
  input  logic                  par_check_err,
  input  logic                  stop_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  samp_en,
  output logic                  samp_done,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stop_chk_en,
  output logic                  data_valid,
  output logic                  framing_err,
  output logic                  parity_err,
  output logic                  break_det
);

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q, stop2_q;

  // Per-frame flags, cleared when a frame starts.
  logic glitch_q;    // start bit judged a glitch
  logic par_err_q;   // parity checker reported a mismatch
  logic stop_err_q;  // some stop bit sampled low
  logic brk_or_q;    // OR of every data/parity sample; 0 means line stayed low
  logic chk_d_q;     // a check strobe fired last cycle: checker result is valid now

  logic                  active, active_d, end_of_bit, chk_slot, start_frame;
  logic                  last_stop, glitch_now, stop_err_now, is_break;
  logic [PRESCALE_W-1:0] samp_pt, chk_pt;
  logic [BIT_CNT_W-1:0]  last_bit;

  assign active   = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign active_d = (state_d == ST_START) || (state_d == ST_DATA) ||
                    (state_d == ST_PARITY) || (state_d == ST_STOP);

  // Counters are cleared whenever the next state is not a frame state, so
  // they already read 0 in the first IDLE/BREAK cycle after a frame.
  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_cnt (
    .clck       (clck),
    .rst        (rst),
    .en         (active),
    .clr        (!active_d),
    .prescale   (prescale_q),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .end_of_bit (end_of_bit)
  );

  assign samp_pt  = (prescale_q >> 1) + PRESCALE_W'(1);
  assign chk_pt   = samp_pt + PRESCALE_W'(1);
  assign chk_slot = active && (edge_cnt == chk_pt);

  assign samp_en     = active;
  assign samp_done   = active && (edge_cnt == samp_pt);
  assign strt_chk_en = (state_q == ST_START)  && chk_slot;
  assign deser_en    = (state_q == ST_DATA)   && chk_slot;
  assign par_chk_en  = (state_q == ST_PARITY) && chk_slot;
  assign stop_chk_en = (state_q == ST_STOP)   && chk_slot;

  assign start_frame = (state_q == ST_IDLE) && !RX_IN;
  assign last_bit    = BIT_CNT_W'(DATA_WIDTH + 1) + BIT_CNT_W'(par_en_q) +
                       BIT_CNT_W'(stop2_q);
  assign last_stop   = (state_q == ST_STOP) && end_of_bit && (bit_cnt == last_bit);

  // At prescale=8 the checker answer arrives in the end_of_bit cycle itself,
  // so the live result is merged with the latched one.
  assign glitch_now   = glitch_q   || (chk_d_q && strt_glitch);
  assign stop_err_now = stop_err_q || (chk_d_q && stop_err);
  assign is_break     = !brk_or_q && stop_err_now;

  // NOTE: every combinational output gets a default first, so no path through
  // the case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!RX_IN) state_d = ST_START;
      ST_START:  if (end_of_bit) state_d = glitch_now ? ST_IDLE : ST_DATA;
      ST_DATA:   if (end_of_bit && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                   state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (end_of_bit) state_d = ST_STOP;
      ST_STOP:   if (last_stop) state_d = is_break ? ST_BREAK : ST_IDLE;
      ST_BREAK:  if (RX_IN) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Exactly one outcome in the last frame cycle; break suppresses the rest,
  // framing and parity errors may report together.
  always_comb begin
    data_valid  = 1'b0;
    framing_err = 1'b0;
    parity_err  = 1'b0;
    break_det   = 1'b0;
    if (last_stop) begin
      if (is_break) begin
        break_det = 1'b1;
      end else if (stop_err_now || par_err_q) begin
        framing_err = stop_err_now;
        parity_err  = par_err_q;
      end else begin
        data_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      glitch_q   <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      brk_or_q   <= 1'b0;
      chk_d_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_d_q <= chk_slot;
      if (start_frame) begin
        prescale_q <= prescale;
        par_en_q   <= par_en;
        stop2_q    <= stop2;
        glitch_q   <= 1'b0;
        par_err_q  <= 1'b0;
        stop_err_q <= 1'b0;
        brk_or_q   <= 1'b0;
      end else begin
        if ((state_q == ST_START) && chk_d_q && strt_glitch) glitch_q <= 1'b1;
        if ((state_q == ST_PARITY) && chk_d_q && par_check_err) par_err_q <= 1'b1;
        if ((state_q == ST_STOP) && chk_d_q && stop_err) stop_err_q <= 1'b1;
        if (((state_q == ST_DATA) || (state_q == ST_PARITY)) && samp_done && sampled_bit)
          brk_or_q <= 1'b1;
      end
    end
  end

endmodule
